// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq
//  Purpose  : Board-level reset sequencer. Merges the power-on/pushbutton
//             reset, an external reset pin and a software reset request into
//             a single sequence. All channels are held in reset for
//             HOLD_CYCLES after the last source goes quiet, then released
//             one by one, STAGGER cycles apart. Reports a ready flag and the
//             cause of the most recent reset.
//
//  Ports    : clk_in     in   system clock
//             rst_in_n   in   async active-low power-on/pushbutton reset
//             ext_rst_n  in   external active-low reset (synchronised)
//             sw_rst_req in   software reset request, level, clk_in domain
//             clk        out  copy of clk_in
//             rst        out  [N_OUT] active-high resets, bit k released k-th
//             ready      out  high once every channel is released
//             rst_cause  out  00 rst_in_n, 01 ext_rst_n, 10 sw_rst_req
//
//  Revision : 1.0  initial release
// ============================================================================
module rst_seq #(
    parameter int N_OUT       = 4,
    parameter int HOLD_CYCLES = 16777215,
    parameter int STAGGER     = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic             ext_rst_n,
    input  logic             sw_rst_req,
    output logic             clk,
    output logic [N_OUT-1:0] rst,
    output logic             ready,
    output logic [1:0]       rst_cause
);

    // ------------------------------------------------------------------------
    // Derived widths. Counters are sized one value wider than the terminal
    // count so HOLD_CYCLES / STAGGER themselves are representable.
    // ------------------------------------------------------------------------
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_STAG_W = $clog2(STAGGER + 1);
    localparam int c_IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_STAG_W-1:0] c_STAG_LAST = c_STAG_W'(STAGGER - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(N_OUT - 1);

    // State encoding
    localparam logic [1:0] c_ST_ASSERT  = 2'd0;
    localparam logic [1:0] c_ST_RELEASE = 2'd1;
    localparam logic [1:0] c_ST_RUN     = 2'd2;

    // Cause encoding
    localparam logic [1:0] c_CAUSE_POR = 2'b00;
    localparam logic [1:0] c_CAUSE_EXT = 2'b01;
    localparam logic [1:0] c_CAUSE_SW  = 2'b10;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync_por;
    logic [SYNC_STAGES-1:0] r_sync_ext;
    logic [1:0]             r_state;
    logic [c_HOLD_W-1:0]    r_hold;
    logic [c_STAG_W-1:0]    r_stag;
    logic [c_IDX_W-1:0]     r_idx;
    logic [N_OUT-1:0]       r_rst;
    logic                   r_ready;
    logic [1:0]             r_cause;

    // ------------------------------------------------------------------------
    // Source decode
    // ------------------------------------------------------------------------
    logic             w_src_por;
    logic             w_src_ext;
    logic             w_src_sw;
    logic             w_src_any;
    logic [N_OUT-1:0] w_clr_sel;

    // The oldest flop of each chain is the synchronised level.
    assign w_src_por = ~r_sync_por[SYNC_STAGES-1];
    assign w_src_ext = ~r_sync_ext[SYNC_STAGES-1];
    assign w_src_sw  = sw_rst_req;
    assign w_src_any = w_src_por | w_src_ext | w_src_sw;

    // One-hot select of the channel that the current stagger slot releases.
    genvar k;
    generate
        for (k = 0; k < N_OUT; k++) begin : g_clr_sel
            assign w_clr_sel[k] = (r_idx == c_IDX_W'(k));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Synchronisers. The power-on chain shifts in a constant one, giving
    // asynchronous assertion and synchronous release. The external pin is a
    // plain data synchroniser; it is cleared alongside the power-on chain so
    // both report "active" until the first samples propagate, and the
    // priority order keeps the cause at power-on during that window.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_sync_por <= '0;
            r_sync_ext <= '0;
        end else begin
            r_sync_por <= {r_sync_por[SYNC_STAGES-2:0], 1'b1};
            r_sync_ext <= {r_sync_ext[SYNC_STAGES-2:0], ext_rst_n};
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state <= c_ST_ASSERT;
            r_hold  <= '0;
            r_stag  <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_cause <= c_CAUSE_POR;
        end else if (w_src_any) begin
            // Any active source restarts the whole sequence from any state,
            // and keeps restarting the hold count while it stays active.
            r_state <= c_ST_ASSERT;
            r_hold  <= '0;
            r_stag  <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_ready <= 1'b0;
            if (w_src_por) begin
                r_cause <= c_CAUSE_POR;
            end else if (w_src_ext) begin
                r_cause <= c_CAUSE_EXT;
            end else begin
                r_cause <= c_CAUSE_SW;
            end
        end else begin
            case (r_state)
                c_ST_ASSERT: begin
                    if (r_hold == c_HOLD_LAST) begin
                        // Channel 0 is released directly at the end of the
                        // hold interval; a single-channel build is done.
                        r_rst[0] <= 1'b0;
                        r_stag   <= '0;
                        if (N_OUT == 1) begin
                            r_state <= c_ST_RUN;
                            r_ready <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_state <= c_ST_RELEASE;
                            r_idx   <= c_IDX_W'(1);
                        end
                    end else begin
                        r_hold <= r_hold + c_HOLD_W'(1);
                    end
                end

                c_ST_RELEASE: begin
                    if (r_stag == c_STAG_LAST) begin
                        r_rst  <= r_rst & ~w_clr_sel;
                        r_stag <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end else begin
                        r_stag <= r_stag + c_STAG_W'(1);
                    end
                end

                c_ST_RUN: begin
                    r_rst   <= '0;
                    r_ready <= 1'b1;
                end

                default: begin
                    // Unreachable encoding: fall back to a full reset.
                    r_state <= c_ST_ASSERT;
                    r_hold  <= '0;
                    r_stag  <= '0;
                    r_idx   <= '0;
                    r_rst   <= '1;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Only the clock passes through combinationally.
    // ------------------------------------------------------------------------
    assign clk       = clk_in;
    assign rst       = r_rst;
    assign ready     = r_ready;
    assign rst_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_seq
//  Purpose  : Self-checking bench for rst_seq (3-channel and 1-channel builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rst_seq;

    localparam int N    = 3;
    localparam int HOLD = 8;
    localparam int STAG = 4;
    localparam int SYNC = 2;
    localparam int FULL = HOLD + (N - 1) * STAG;

    logic         clk_in = 1'b0;
    logic         rst_in_n;
    logic         ext_rst_n;
    logic         sw_rst_req;
    logic         clk;
    logic [N-1:0] rst;
    logic         ready;
    logic [1:0]   rst_cause;

    logic         ext_b;
    logic         sw_b;
    logic         clk_b;
    logic [0:0]   rst_b;
    logic         ready_b;
    logic [1:0]   cause_b;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    rst_seq #(
        .N_OUT      (N),
        .HOLD_CYCLES(HOLD),
        .STAGGER    (STAG),
        .SYNC_STAGES(SYNC)
    ) u_dut (
        .clk_in    (clk_in),
        .rst_in_n  (rst_in_n),
        .ext_rst_n (ext_rst_n),
        .sw_rst_req(sw_rst_req),
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .rst_cause (rst_cause)
    );

    rst_seq #(
        .N_OUT      (1),
        .HOLD_CYCLES(1),
        .STAGGER    (1),
        .SYNC_STAGES(2)
    ) u_dut_b (
        .clk_in    (clk_in),
        .rst_in_n  (rst_in_n),
        .ext_rst_n (ext_b),
        .sw_rst_req(sw_b),
        .clk       (clk_b),
        .rst       (rst_b),
        .ready     (ready_b),
        .rst_cause (cause_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: m_q counts consecutive edges with no active source.
    // Channel k is out of reset once that quiet run reaches HOLD + k*STAG.
    // ------------------------------------------------------------------------
    int              m_q;
    int              m_por_cnt;
    logic [SYNC-1:0] m_eh;
    logic [1:0]      m_cause;
    logic            m_por_a;
    logic            m_ext_a;
    logic [N-1:0]    m_rst;
    logic            m_ready;

    assign m_por_a = (m_por_cnt < SYNC);
    assign m_ext_a = ~m_eh[SYNC-1];

    always @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            m_q       <= 0;
            m_por_cnt <= 0;
            m_eh      <= '0;
            m_cause   <= 2'b00;
        end else begin
            if (m_por_a || m_ext_a || sw_rst_req) begin
                m_q     <= 0;
                m_cause <= m_por_a ? 2'b00 : (m_ext_a ? 2'b01 : 2'b10);
            end else if (m_q < FULL) begin
                m_q <= m_q + 1;
            end
            if (m_por_cnt < SYNC) m_por_cnt <= m_por_cnt + 1;
            m_eh <= {m_eh[SYNC-2:0], ext_rst_n};
        end
    end

    always_comb begin
        m_rst = '0;
        for (int k = 0; k < N; k++) m_rst[k] = (m_q < HOLD + k * STAG);
        m_ready = (m_q >= FULL);
    end

    always @(negedge clk_in) begin
        chk("model_rst",   32'(rst),       32'(m_rst));
        chk("model_ready", 32'(ready),     32'(m_ready));
        chk("model_cause", 32'(rst_cause), 32'(m_cause));
    end

    // ------------------------------------------------------------------------
    // Single-channel build: rst[0] and ready change together at edge 3.
    // ------------------------------------------------------------------------
    initial begin
        @(negedge clk_in);
        chk("b_reset_rst",   32'(rst_b),   32'd1);
        chk("b_reset_ready", 32'(ready_b), 32'd0);
        @(posedge rst_in_n);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("b_edge2_rst",   32'(rst_b),   32'd1);
        chk("b_edge2_ready", 32'(ready_b), 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("b_edge3_rst",   32'(rst_b),   32'd0);
        chk("b_edge3_ready", 32'(ready_b), 32'd1);
        chk("b_edge3_cause", 32'(cause_b), 32'd0);
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic chk3(input string nm, input logic [2:0] er, input logic erdy, input logic [1:0] ec);
        chk({nm, "_rst"},   32'(rst),       32'(er));
        chk({nm, "_ready"}, 32'(ready),     32'(erdy));
        chk({nm, "_cause"}, 32'(rst_cause), 32'(ec));
    endtask

    typedef struct {
        int         adv;
        logic       sw;
        logic       ext;
        logic [2:0] rst;
        logic       rdy;
        logic [1:0] cause;
    } vec_t;

    vec_t tbl [14];
    int   ext_left;

    initial begin
        // power-on sequence (edge counts from rst_in_n release), then a
        // one-cycle software request at R = edge 21
        tbl[0]  = '{9, 1'b0, 1'b1, 3'b111, 1'b0, 2'b00};
        tbl[1]  = '{1, 1'b0, 1'b1, 3'b110, 1'b0, 2'b00};
        tbl[2]  = '{3, 1'b0, 1'b1, 3'b110, 1'b0, 2'b00};
        tbl[3]  = '{1, 1'b0, 1'b1, 3'b100, 1'b0, 2'b00};
        tbl[4]  = '{3, 1'b0, 1'b1, 3'b100, 1'b0, 2'b00};
        tbl[5]  = '{1, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00};
        tbl[6]  = '{2, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00};
        tbl[7]  = '{1, 1'b1, 1'b1, 3'b111, 1'b0, 2'b10};
        tbl[8]  = '{7, 1'b0, 1'b1, 3'b111, 1'b0, 2'b10};
        tbl[9]  = '{1, 1'b0, 1'b1, 3'b110, 1'b0, 2'b10};
        tbl[10] = '{3, 1'b0, 1'b1, 3'b110, 1'b0, 2'b10};
        tbl[11] = '{1, 1'b0, 1'b1, 3'b100, 1'b0, 2'b10};
        tbl[12] = '{3, 1'b0, 1'b1, 3'b100, 1'b0, 2'b10};
        tbl[13] = '{1, 1'b0, 1'b1, 3'b000, 1'b1, 2'b10};

        rst_in_n   = 1'b0;
        ext_rst_n  = 1'b1;
        sw_rst_req = 1'b0;
        ext_b      = 1'b1;
        sw_b       = 1'b0;
        ext_left   = 0;

        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        chk3("reset", 3'b111, 1'b0, 2'b00);
        chk("clk_low", 32'(clk), 32'(clk_in));
        rst_in_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            sw_rst_req = tbl[i].sw;
            ext_rst_n  = tbl[i].ext;
            adv(tbl[i].adv);
            chk3($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rdy, tbl[i].cause);
        end
        sw_rst_req = 1'b0;

        // async pulse from RUN, low for 3 ns, released before the next edge
        #1 rst_in_n = 1'b0;
        #1 chk3("async", 3'b111, 1'b0, 2'b00);
        #2 rst_in_n = 1'b1;
        adv(9);
        chk3("async_e9", 3'b111, 1'b0, 2'b00);
        adv(1);
        chk3("async_e10", 3'b110, 1'b0, 2'b00);
        adv(4);
        chk3("async_e14", 3'b100, 1'b0, 2'b00);
        adv(4);
        chk3("async_e18", 3'b000, 1'b1, 2'b00);

        // into RELEASE via software request, then ext_rst_n low for 3 cycles
        sw_rst_req = 1'b1;
        adv(1);
        sw_rst_req = 1'b0;
        adv(8);
        chk3("pre_ext", 3'b110, 1'b0, 2'b10);
        ext_rst_n = 1'b0;
        adv(3);
        chk3("ext_hit", 3'b111, 1'b0, 2'b01);
        ext_rst_n = 1'b1;
        adv(9);
        chk3("ext_hold", 3'b111, 1'b0, 2'b01);
        adv(1);
        chk3("ext_rel0", 3'b110, 1'b0, 2'b01);
        adv(8);
        chk3("ext_run", 3'b000, 1'b1, 2'b01);

        // software request coinciding with synchronised ext_rst_n low
        ext_rst_n = 1'b0;
        adv(2);
        sw_rst_req = 1'b1;
        adv(1);
        chk3("both_hit", 3'b111, 1'b0, 2'b01);
        ext_rst_n  = 1'b1;
        sw_rst_req = 1'b0;
        adv(9);
        chk3("both_hold", 3'b111, 1'b0, 2'b01);
        adv(1);
        chk3("both_rel0", 3'b110, 1'b0, 2'b01);

        // random traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            sw_rst_req = ($urandom_range(0, 29) == 0);
            if (ext_left > 0) begin
                ext_rst_n = 1'b0;
                ext_left--;
            end else begin
                ext_rst_n = 1'b1;
                if ($urandom_range(0, 39) == 0) ext_left = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_in_n = 1'b0;
                #3 rst_in_n = 1'b1;
            end
            @(negedge clk_in);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
